// File: rtl/board_state.sv
// rtl/board_state.sv - 10x10 battleship grid owner: placement scan/write, fire resolution, hit/ship counters.
module board_state #(
  parameter int GRID_N  = 10,
  parameter int MAX_LEN = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         place_req,
  input  logic                         fire_req,
  input  logic [3:0]                   row,
  input  logic [3:0]                   col,
  input  logic                         vertical,
  input  logic [2:0]                   length,
  output logic                         busy,
  output logic                         place_done,
  output logic                         place_ok,
  output logic                         fire_done,
  output logic [1:0]                   fire_result,
  output logic [6:0]                   ship_cells,
  output logic [6:0]                   hit_count,
  output logic                         all_sunk,
  output logic [2*GRID_N*GRID_N-1:0]   cell_status_flat
);

  localparam int CELLS = GRID_N * GRID_N;
  localparam int IW    = $clog2(CELLS);
  localparam int FW    = $clog2(2 * CELLS);
  localparam logic [6:0] CNT_MAX = 7'(CELLS);

  localparam logic [1:0] WATER = 2'b00;
  localparam logic [1:0] SHIP  = 2'b01;
  localparam logic [1:0] MISS  = 2'b10;
  localparam logic [1:0] HIT   = 2'b11;

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, FIRE} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] bow;
  logic [IW-1:0] step;
  logic [2:0]    len;
  logic [2:0]    cnt;
  logic          fire_ok;

  logic [IW-1:0] req_idx;
  logic [4:0]    stern;
  logic          place_bad;
  logic          coord_ok;
  logic [FW-1:0] ptr_bit;
  logic [1:0]    cur_cell;

  assign req_idx  = IW'(row) * IW'(GRID_N) + IW'(col);
  assign coord_ok = (int'(row) < GRID_N) && (int'(col) < GRID_N);
  // Stern coordinate along the placement axis; only meaningful when length != 0.
  assign stern    = vertical ? (5'(row) + 5'(length) - 5'd1) : (5'(col) + 5'(length) - 5'd1);
  assign place_bad = (length == 3'd0) || (int'(length) > MAX_LEN) || !coord_ok ||
                     (int'(stern) > GRID_N - 1);

  assign ptr_bit  = FW'(ptr) << 1;
  assign cur_cell = cell_status_flat[ptr_bit +: 2];
  assign all_sunk = (hit_count == ship_cells) && (ship_cells != 7'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      busy             <= 1'b0;
      place_done       <= 1'b0;
      place_ok         <= 1'b0;
      fire_done        <= 1'b0;
      fire_result      <= 2'b00;
      ship_cells       <= 7'd0;
      hit_count        <= 7'd0;
      cell_status_flat <= '0;
      ptr              <= '0;
      bow              <= '0;
      step             <= '0;
      len              <= 3'd0;
      cnt              <= 3'd0;
      fire_ok          <= 1'b0;
    end else begin
      place_done <= 1'b0;
      fire_done  <= 1'b0;
      if (clear) begin
        state            <= IDLE;
        busy             <= 1'b0;
        place_ok         <= 1'b0;
        fire_result      <= 2'b00;
        ship_cells       <= 7'd0;
        hit_count        <= 7'd0;
        cell_status_flat <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (fire_req) begin
              state   <= FIRE;
              busy    <= 1'b1;
              ptr     <= req_idx;
              fire_ok <= coord_ok;
            end else if (place_req) begin
              if (place_bad) begin
                place_done <= 1'b1;
                place_ok   <= 1'b0;
              end else begin
                state <= CHECK;
                busy  <= 1'b1;
                ptr   <= req_idx;
                bow   <= req_idx;
                step  <= vertical ? IW'(GRID_N) : IW'(1);
                len   <= length;
                cnt   <= 3'd0;
              end
            end
          end

          CHECK: begin
            if (cur_cell != WATER) begin
              state      <= IDLE;
              busy       <= 1'b0;
              place_done <= 1'b1;
              place_ok   <= 1'b0;
            end else if (cnt == len - 3'd1) begin
              state <= WRITE;
              ptr   <= bow;
              cnt   <= 3'd0;
            end else begin
              ptr <= ptr + step;
              cnt <= cnt + 3'd1;
            end
          end

          WRITE: begin
            cell_status_flat[ptr_bit +: 2] <= SHIP;
            if (ship_cells != CNT_MAX) ship_cells <= ship_cells + 7'd1;
            if (cnt == len - 3'd1) begin
              state      <= IDLE;
              busy       <= 1'b0;
              place_done <= 1'b1;
              place_ok   <= 1'b1;
            end else begin
              ptr <= ptr + step;
              cnt <= cnt + 3'd1;
            end
          end

          FIRE: begin
            state     <= IDLE;
            busy      <= 1'b0;
            fire_done <= 1'b1;
            if (!fire_ok) begin
              fire_result <= 2'b11;
            end else begin
              unique case (cur_cell)
                WATER: begin
                  cell_status_flat[ptr_bit +: 2] <= MISS;
                  fire_result <= 2'b01;
                end
                SHIP: begin
                  cell_status_flat[ptr_bit +: 2] <= HIT;
                  if (hit_count != CNT_MAX) hit_count <= hit_count + 7'd1;
                  fire_result <= 2'b10;
                end
                default: fire_result <= 2'b11;
              endcase
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
